// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, byte-lane writes and same-word write forwarding.
// Optional build macro AHB_SRAM_ERRRESP_EN adds ERROR responses for misaligned, oversize and out-of-range transfers.
module ahb_sram_slave #(
  parameter int ADDRWIDTH   = 32,
  parameter int DATAWIDTH   = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [1:0]           HTRANS,
  input  logic [DATAWIDTH-1:0] HWDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [DATAWIDTH-1:0] HRDATA
);

  localparam int         BYTES = DATAWIDTH / 8;
  localparam int         OFFW  = $clog2(BYTES);
  localparam int         IDXW  = $clog2(DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic [DATAWIDTH-1:0]  mem [DEPTH];

  logic                  accept, err, commit;
  logic [OFFW-1:0]       off_p0;
  logic [IDXW-1:0]       idx_p0, idx_p1;
  logic [BYTES-1:0]      mask_p0, mask_p1;
  logic                  vld_p1;
  logic [DATAWIDTH-1:0]  rd_fwd_p0;
  logic                  unused_ok;

  function automatic logic [BYTES-1:0] lane_mask(input logic [OFFW-1:0] off,
                                                 input logic [2:0]      size);
    int nb;
    nb = 1 << size;
    for (int b = 0; b < BYTES; b++)
      lane_mask[b] = (b >= int'(off)) && (b < int'(off) + nb);
  endfunction

  function automatic logic [DATAWIDTH-1:0] merge(input logic [DATAWIDTH-1:0] old_d,
                                                 input logic [DATAWIDTH-1:0] wdata,
                                                 input logic [BYTES-1:0]     m);
    for (int b = 0; b < BYTES; b++)
      merge[8*b +: 8] = m[b] ? wdata[8*b +: 8] : old_d[8*b +: 8];
  endfunction

  assign unused_ok = ^{HBURST, HTRANS[0], HADDR};

  // ---- stage p0: address phase decode
  assign off_p0  = HADDR[OFFW-1:0];
  assign idx_p0  = HADDR[OFFW +: IDXW];
  assign mask_p0 = lane_mask(off_p0, HSIZE);
  assign accept  = HREADY && HSEL && HTRANS[1];

`ifdef AHB_SRAM_ERRRESP_EN
  logic oversize, misalign, range_err;
  always_comb begin
    oversize  = int'(HSIZE) > OFFW;
    misalign  = 1'b0;
    range_err = 1'b0;
    for (int b = 0; b < OFFW; b++)
      if (b < int'(HSIZE) && off_p0[b]) misalign = 1'b1;
    for (int b = OFFW + IDXW; b < ADDRWIDTH; b++)
      if (HADDR[b]) range_err = 1'b1;
  end
  assign err    = oversize || misalign || range_err;
  assign HRESP  = (state == ERR1) || (state == ERR2);
`else
  assign err    = 1'b0;
  assign HRESP  = 1'b0;
`endif

  assign HREADY = (state == IDLE) || (state == ERR2);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = IDLE;
      end
`ifdef AHB_SRAM_ERRRESP_EN
      ERR1:    state_nx = ERR2;
`endif
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      if (err) begin
        state_nx = ERR1;
      end else if (WS != 4'd0) begin
        state_nx = WAIT;
        cnt_nx   = WS;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  // A write committing this edge to the word being read is merged into the read data.
  assign commit    = HREADY && vld_p1;
  assign rd_fwd_p0 = (commit && (idx_p1 == idx_p0)) ? merge(mem[idx_p0], HWDATA, mask_p1)
                                                    : mem[idx_p0];

  // ---- stage p1: data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      vld_p1 <= 1'b0;
      HRDATA <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (HREADY) vld_p1 <= accept && HWRITE && !err;
      if (accept && !HWRITE && !err) HRDATA <= rd_fwd_p0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept) begin
      idx_p1  <= idx_p0;
      mask_p1 <= mask_p0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) mem[idx_p1] <= merge(mem[idx_p1], HWDATA, mask_p1);
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized bench for ahb_sram_slave: three instances (0, 3, 5 wait states) share one bus
// and are checked against a byte-array memory model with an ideal AHB transfer timing model.
module tb_ahb_sram_slave;

  localparam int         DEPTH  = 64;
  localparam int         NB     = DEPTH * 4;
  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel_bus;
  logic [1:0]  act;
  logic [2:0]  hsel, hready, hresp;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;
  logic [31:0] hrdata [3];

  logic [7:0]  mdl [3][NB];
  xfer_t       q[$];
  logic [31:0] last_rd;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  assign hsel = hsel_bus ? (3'b001 << act) : 3'b000;

  ahb_sram_slave #(.ADDRWIDTH(32), .DATAWIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HREADY(hready[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

  ahb_sram_slave #(.ADDRWIDTH(32), .DATAWIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HREADY(hready[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

  ahb_sram_slave #(.ADDRWIDTH(32), .DATAWIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(5)) u_ws5 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[2]), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata),
    .HREADY(hready[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ws_of(input logic [1:0] k);
    case (k)
      2'd0:    return 0;
      2'd1:    return 3;
      default: return 5;
    endcase
  endfunction

  function automatic bit is_err(input xfer_t t);
`ifdef AHB_SRAM_ERRRESP_EN
    int n = 1 << t.size;
    return (n > 4) || ((int'(t.addr) % n) != 0) || (t.addr >= 32'(NB));
`else
    return (t.size > 3'd7);
`endif
  endfunction

  function automatic logic [31:0] mdl_word(input logic [1:0] k, input logic [31:0] a);
    int base = int'((a / 32'd4) % 32'(DEPTH)) * 4;
    return {mdl[k][base+3], mdl[k][base+2], mdl[k][base+1], mdl[k][base]};
  endfunction

  task automatic mdl_write(input logic [1:0] k, input xfer_t t);
    int n    = 1 << t.size;
    int off  = int'(t.addr % 32'd4);
    int base = int'((t.addr / 32'd4) % 32'(DEPTH)) * 4;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + n) mdl[k][base+b] = t.wdata[8*b +: 8];
  endtask

  task automatic push(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    xfer_t t;
    t.sel = sel; t.trans = tr; t.wr = wr; t.addr = a; t.size = sz; t.wdata = wd;
    q.push_back(t);
  endtask

  task automatic add_random(input int n);
    for (int j = 0; j < n; j++) begin
      xfer_t t;
      int    r;
      int    nbyte;
      r       = int'($urandom_range(0, 99));
      t.sel   = ($urandom_range(0, 9) != 0);
      t.trans = (r < 10) ? T_IDLE : (r < 20) ? T_BUSY : (r < 60) ? T_NSEQ : T_SEQ;
      t.wr    = 1'($urandom_range(0, 1));
      t.size  = 3'($urandom_range(0, 3));
      r       = int'($urandom_range(0, 9));
      t.addr  = (r < 5) ? 32'($urandom_range(0, 31)) :
                (r < 9) ? 32'($urandom_range(0, NB-1)) : 32'($urandom_range(NB, 2*NB-1));
      nbyte   = 1 << t.size;
      if ($urandom_range(0, 4) != 0) t.addr = t.addr & ~(32'(nbyte) - 32'd1);
      t.wdata = $urandom;
      q.push_back(t);
    end
  endtask

  task automatic drive_addr(input int j);
    if (j < q.size()) begin
      hsel_bus = q[j].sel;
      htrans   = q[j].trans;
      hwrite   = q[j].wr;
      haddr    = q[j].addr;
      hsize    = q[j].size;
    end else begin
      hsel_bus = 1'b0;
      htrans   = T_IDLE;
      hwrite   = 1'b0;
    end
  endtask

  // Pipelined master: called and returns at a negedge; executes every queued transfer on instance k.
  task automatic run_seq(input logic [1:0] k);
    xfer_t dp;
    bit    dp_on = 0, dp_act = 0, dp_err = 0;
    int    dp_cyc = 0, lat = 0, i = 0;
    logic  rdy;
    act = k;
    drive_addr(0);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      rdy = hready[k];
      if (dp_on) begin
        chk("hready", 32'(rdy), 32'(dp_cyc == lat));
        chk("hresp", 32'(hresp[k]), 32'(dp_err));
        if (rdy && dp_act && !dp_err) begin
          if (dp.wr) mdl_write(k, dp);
          else begin
            chk("hrdata", hrdata[k], mdl_word(k, dp.addr));
            last_rd = hrdata[k];
          end
        end
        if (!rdy && dp_cyc > 20) begin
          chk("dp_timeout", 32'(dp_cyc), 32'd20);
          break;
        end
        dp_cyc++;
      end else begin
        chk("idle_hready", 32'(rdy), 32'd1);
      end
      if (rdy && i >= q.size()) break;
      @(posedge clk);
      #1;
      if (rdy) begin
        dp     = q[i];
        dp_on  = 1;
        dp_act = dp.sel && dp.trans[1];
        dp_err = dp_act && is_err(dp);
        lat    = !dp_act ? 0 : dp_err ? 1 : ws_of(k);
        dp_cyc = 0;
        i++;
        drive_addr(i);
        hwdata = dp.wdata;
      end
      @(negedge clk);
    end
    q.delete();
    drive_addr(0);
  endtask

  task automatic chk_reset_vals(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_hready"}, 32'(hready[k]), 32'd1);
      chk({tag, "_hresp"}, 32'(hresp[k]), 32'd0);
      chk({tag, "_hrdata"}, hrdata[k], 32'd0);
    end
  endtask

  initial begin
    hresetn  = 1'b0;
    hsel_bus = 1'b0;
    act      = 2'd0;
    htrans   = T_IDLE;
    hwrite   = 1'b0;
    haddr    = '0;
    hsize    = 3'd2;
    hburst   = 3'd0;
    hwdata   = '0;
    last_rd  = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    hresetn = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < DEPTH; w++) push(1, T_NSEQ, 1, 32'(w * 4), 3'd2, $urandom);
      run_seq(2'(k));
    end

    push(1, T_NSEQ, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    push(1, T_NSEQ, 0, 32'h10, 3'd2, 32'h0);
    run_seq(2'd0);
    chk("b2b_fwd", last_rd, 32'hDEADBEEF);

    for (int k = 0; k < 2; k++) begin
      push(1, T_NSEQ, 1, 32'h20, 3'd2, 32'h11223344);
      push(1, T_NSEQ, 1, 32'h22, 3'd0, 32'h00AA0000);
      push(1, T_NSEQ, 0, 32'h20, 3'd2, 32'h0);
      run_seq(2'(k));
      chk("byte_merge", last_rd, 32'h11AA3344);
    end

    push(1, T_NSEQ, 0, 32'h0, 3'd2, 32'h0);
    run_seq(2'd1);

    hburst = 3'b011;
    for (int k = 0; k < 2; k++) begin
      push(1, T_NSEQ, 1, 32'h40, 3'd2, 32'hA0A0A0A0);
      push(1, T_BUSY, 1, 32'h44, 3'd2, 32'hBADBAD00);
      push(1, T_SEQ,  1, 32'h44, 3'd2, 32'hB1B1B1B1);
      push(0, T_SEQ,  1, 32'h48, 3'd2, 32'hBADBAD01);
      push(1, T_SEQ,  1, 32'h48, 3'd2, 32'hC2C2C2C2);
      push(1, T_SEQ,  1, 32'h4C, 3'd2, 32'hD3D3D3D3);
      for (int w = 0; w < 4; w++) push(1, T_NSEQ, 0, 32'(32'h40 + w * 4), 3'd2, 32'h0);
      run_seq(2'(k));
      chk("burst_last", last_rd, 32'hD3D3D3D3);
    end
    hburst = 3'd0;

`ifdef AHB_SRAM_ERRRESP_EN
    push(1, T_NSEQ, 1, 32'h3, 3'd1, 32'hFFFFFFFF);
    push(1, T_NSEQ, 1, 32'h4, 3'd3, 32'hFFFFFFFF);
    push(1, T_NSEQ, 1, 32'(NB), 3'd2, 32'hFFFFFFFF);
    push(1, T_NSEQ, 0, 32'h0, 3'd2, 32'h0);
    run_seq(2'd0);
`endif

    for (int k = 0; k < 3; k++) begin
      add_random(80);
      run_seq(2'(k));
    end

    // Reset in the second wait cycle of a write must abort it.
    push(1, T_NSEQ, 1, 32'h8, 3'd2, 32'hCAFEF00D);
    run_seq(2'd2);
    act      = 2'd2;
    hsel_bus = 1'b1;
    htrans   = T_NSEQ;
    hwrite   = 1'b1;
    haddr    = 32'h8;
    hsize    = 3'd2;
    @(posedge clk);
    #1;
    drive_addr(0);
    hwdata = 32'h55;
    @(negedge clk);
    chk("ws_cycle1", 32'(hready[2]), 32'd0);
    @(posedge clk);
    #1;
    hresetn = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    @(negedge clk);
    hresetn = 1'b1;
    @(negedge clk);
    push(1, T_NSEQ, 0, 32'h8, 3'd2, 32'h0);
    run_seq(2'd2);
    chk("abort_not_55", 32'(last_rd == 32'h55), 32'd0);
    chk("abort_kept", last_rd, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
